// File: rtl/led7seg_scan_if.sv
// Display update bus for led7seg_scan: enable, load strobe, digits and DPs in,
// busy flag and shared segment lines out.
interface led7seg_scan_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   data;
    logic [DIGITS-1:0]     dp;
    logic                  busy;
    logic [7:0]            led;

    modport master (
        output en, load, data, dp,
        input  busy, led
    );

    modport slave (
        input  en, load, data, dp,
        output busy, led
    );
endinterface

// File: rtl/led7seg_scan.sv
// Multiplexed N-digit hex 7-segment driver with frame-synchronised updates,
// dead time between digit slots and optional leading-zero blanking.
module led7seg_scan #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEAD     = 16,
    parameter int LZB      = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    led7seg_scan_if.slave     bus,
    output wire [DIGITS-1:0]  o_sa
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0]         r_pre;
    logic [IW-1:0]         r_idx;
    logic [4*DIGITS-1:0]   r_disp_data;
    logic [DIGITS-1:0]     r_disp_dp;
    logic [4*DIGITS-1:0]   r_pend_data;
    logic [DIGITS-1:0]     r_pend_dp;
    logic                  r_busy;

    logic                  w_frame_end;
    logic                  w_dead;
    logic [3:0]            w_nib;
    logic [6:0]            w_font;
    logic [DIGITS-1:0]     w_blank;
    logic [DIGITS-1:0]     w_sel;
    logic [7:0]            w_led;

    assign w_frame_end = (r_idx == IDX_LAST) && (r_pre == PRE_LAST);

    generate
        if (DEAD == 0) begin : g_nodead
            assign w_dead = 1'b0;
        end else begin : g_dead
            assign w_dead = (r_pre < PW'(DEAD));
        end
    endgenerate

    // Scan counters plus pending/display registers; display only moves at frame end.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pre       <= '0;
            r_idx       <= '0;
            r_disp_data <= '0;
            r_disp_dp   <= '0;
            r_pend_data <= '0;
            r_pend_dp   <= '0;
            r_busy      <= 1'b0;
        end else begin
            if (r_pre == PRE_LAST) begin
                r_pre <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
            end else begin
                r_pre <= r_pre + PW'(1);
            end
            if (w_frame_end) begin
                r_busy <= 1'b0;
                if (bus.load) begin
                    r_disp_data <= bus.data;
                    r_disp_dp   <= bus.dp;
                    r_pend_data <= bus.data;
                    r_pend_dp   <= bus.dp;
                end else begin
                    r_disp_data <= r_pend_data;
                    r_disp_dp   <= r_pend_dp;
                end
            end else if (bus.load) begin
                r_pend_data <= bus.data;
                r_pend_dp   <= bus.dp;
                r_busy      <= 1'b1;
            end
        end
    end

    // Digit k>0 is blanked when it and every digit above it are zero.
    always_comb begin
        logic w_allz;
        w_blank = '0;
        w_allz  = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_allz     = w_allz & (r_disp_data[4*k +: 4] == 4'h0);
            w_blank[k] = (LZB != 0) && w_allz;
        end
    end

    assign w_nib = r_disp_data[4*r_idx +: 4];

    // Hex font for the board's active-low a..g segments.
    always_comb begin
        case (w_nib)
            4'h0:    w_font = 7'h40;
            4'h1:    w_font = 7'h79;
            4'h2:    w_font = 7'h24;
            4'h3:    w_font = 7'h30;
            4'h4:    w_font = 7'h19;
            4'h5:    w_font = 7'h12;
            4'h6:    w_font = 7'h02;
            4'h7:    w_font = 7'h78;
            4'h8:    w_font = 7'h00;
            4'h9:    w_font = 7'h10;
            4'hA:    w_font = 7'h08;
            4'hB:    w_font = 7'h03;
            4'hC:    w_font = 7'h46;
            4'hD:    w_font = 7'h21;
            4'hE:    w_font = 7'h06;
            default: w_font = 7'h0E;
        endcase
    end

    // Pin drive: everything dark while disabled or inside the dead window.
    always_comb begin
        w_led = 8'hFF;
        w_sel = '0;
        if (bus.en && !w_dead) begin
            w_sel[r_idx] = 1'b1;
            w_led[6:0]   = w_blank[r_idx] ? 7'h7F : w_font;
            w_led[7]     = ~r_disp_dp[r_idx];
        end
    end

    assign bus.led  = w_led;
    assign bus.busy = r_busy;

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_sa
            assign o_sa[k] = w_sel[k] ? 1'b0 : 1'bz;
        end
    endgenerate
endmodule
